imul_wb_buf: RTL
================

// Module: imul_wb_buf
// PURPOSE
//  Writeback capture buffer directly downstream of the integer multiplier.
//  Tracks issued multiply tags through a delay line matching multiplier latency.
//  Captures the 65-bit result and the 6-bit flags, which arrive one clock later, into a small FIFO.
//  Presents the entries on a valid/ready port to the register-file writeback arbiter.
//  Raises issue_stall so that results are never lost while writeback backpressures.
// PARAMETERS
//  LAT    4   clkEn-gated cycles from en/tag_in accepted to Res valid
//  DEPTH  4   FIFO entries (power of 2, >=2)
//  TAG_W  9   destination register tag width
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active high
//  clkEn        in   1      pipeline advance, same signal as the multiplier's
//  flush        in   1      drop all in-flight ops and buffered entries
//  en           in   1      multiply issued this cycle (qualified by clkEn)
//  tag_in       in   TAG_W  destination tag of the issued op
//  Res          in   65     multiplier result, bit 64 = pointer flag
//  flg          in   6      multiplier flags, valid one clk after Res
//  out_vld      out  1      head entry complete (result + flags)
//  out_ready    in   1      arbiter accepts head this cycle
//  out_tag      out  TAG_W  head tag
//  out_res      out  65     head result
//  out_flg      out  6      head flags
//  issue_stall  out  1      upstream must not assert en
//  ovf_err      out  1      sticky: en accepted while issue_stall
// BEHAVIOUR
//  - Reset: delay line, FIFO pointers, count and credit counter are cleared.
//    out_vld=0, issue_stall=0, ovf_err=0. out_tag/out_res/out_flg are 0.
//  - Delay line: LAT stages of {vld,tag}. It shifts only on edges where clkEn=1.
//    Stage 0 loads {en,tag_in}.
//  - Result capture: on an edge where clkEn=1 and stage LAT-1 is valid, the FIFO tail
//    is written with {tag,Res} and flg_pend=1, and the tail advances.
//    On the very next clk edge, regardless of clkEn, flg is written into that entry
//    and flg_pend is cleared.
//  - out_vld = count!=0 && !flg_pend[head]. Outputs read combinationally from the head.
//  - Pop: out_vld && out_ready pops the head on that edge.
//    Push and pop on the same edge leave count unchanged.
//  - Credits: inflight = number of valid delay-line stages.
//    issue_stall = (inflight + count) >= DEPTH.
//    The value is registered from next-state values, so it is correct in the same cycle the issue would occur.
//  - en=1 && clkEn=1 && issue_stall=1: the op is still tracked and ovf_err is set (sticky until rst).
//    The write is dropped if the FIFO is full at capture.
//  - Full FIFO + pop + push on the same edge is legal: the slot is reused with no loss.
//  - Empty FIFO + flg_pend head: out_vld stays 0 until the flag edge.
//  - Pointers wrap modulo DEPTH. count has width $clog2(DEPTH)+1.
//  - flush (priority below rst, above all else):
//    clears all delay-line vld bits, the FIFO count/pointers and pending flag writes.
//    issue_stall=0 on the next cycle. A pop requested in the same cycle is ignored.
//  - rst mid-operation behaves as flush and also clears ovf_err.
//  - clkEn=0: the delay line freezes. Pop and the flag write still operate.
// STRUCTURE
//  - struct.sv: `define IMUL_LAT, `define IMUL_TAG_W, and the 6-bit flag field layout
//    (O,C,-,S,Z,P) shared with the multiplier and writeback.
//  - Sub-module imul_wb_fifo: DEPTH x (TAG_W+65+6) storage, head/tail/count and flg_pend bits.
//    Its interface has separate res and flg write ports.
//  - The top level holds the delay line, the credit logic and ovf_err.
// TESTING
//  1. Single op: en, tag 0x05, Res=0x1234 at stage LAT, flg=6'b000010 next clk.
//     -> out_vld rises LAT+1 clk after issue with tag 5, res 0x1234, flg 2.
//  2. Issue 4 back-to-back with out_ready=0.
//     -> issue_stall=1 from the cycle after the 4th issue.
//     -> FIFO fills to 4, ovf_err stays 0.
//     -> Raise out_ready: 4 pops in tag order.
//  3. Full FIFO, out_ready=1 while a new result captures.
//     -> count stays 4, no entry lost, order preserved.
//  4. clkEn=0 for 3 cycles with 2 ops in flight.
//     -> capture is delayed exactly 3 cycles. Flags are still taken one clk after the capture edge.
//  5. flush with 2 in flight and 2 buffered.
//     -> next cycle out_vld=0, issue_stall=0, and no stale capture ever appears.
//  6. Force en while issue_stall=1 -> ovf_err=1, which holds until rst.
//     rst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/imul_wb_buf_pkg.sv
// Shared multiplier/writeback constants: latency, tag width and the flag field layout.
`ifndef IMUL_WB_DEFS
`define IMUL_WB_DEFS
`define IMUL_LAT 4
`define IMUL_TAG_W 9
`endif

package imul_wb_buf_pkg;
  localparam int IMUL_LAT   = `IMUL_LAT;
  localparam int IMUL_TAG_W = `IMUL_TAG_W;
  localparam int RES_W      = 65;
  localparam int FLG_W      = 6;

  // Flag layout MSB..LSB: O, C, reserved, S, Z, P
  typedef struct packed {
    logic o;
    logic c;
    logic rsv;
    logic s;
    logic z;
    logic p;
  } flg_t;
endpackage

// File: rtl/imul_wb_fifo.sv
// Result FIFO with a split write: {tag,res} on capture, flags one clock later.
module imul_wb_fifo
  import imul_wb_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = IMUL_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_res_we,
  input  logic [TAG_W-1:0]       i_res_tag,
  input  logic [RES_W-1:0]       i_res,
  input  logic [FLG_W-1:0]       i_flg,
  input  logic                   i_pop,
  output logic                   o_vld,
  output logic [TAG_W-1:0]       o_tag,
  output logic [RES_W-1:0]       o_res,
  output logic [FLG_W-1:0]       o_flg,
  output logic [$clog2(DEPTH):0] o_cnt_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [RES_W-1:0] r_res [DEPTH];
  flg_t             r_flg [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW-1:0]    r_head, r_tail, r_flg_idx;
  logic             r_flg_due;
  logic [CW-1:0]    r_cnt;

  logic w_full, w_pop, w_push;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign o_vld     = (r_cnt != '0) && !r_pend[r_head];
  assign w_pop     = o_vld && i_pop && !i_flush;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push    = i_res_we && !i_flush && (!w_full || w_pop);
  assign o_cnt_nxt = i_flush ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);

  assign o_tag = r_tag[r_head];
  assign o_res = r_res[r_head];
  assign o_flg = r_flg[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_flg_idx <= '0;
      r_flg_due <= 1'b0;
      r_cnt     <= '0;
      r_pend    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
        r_res[i] <= '0;
        r_flg[i] <= '0;
      end
    end else begin
      r_cnt <= o_cnt_nxt;
      if (i_flush) begin
        r_head    <= '0;
        r_tail    <= '0;
        r_pend    <= '0;
        r_flg_due <= 1'b0;
      end else begin
        // Flags land in the slot captured on the previous edge, independent of clkEn.
        if (r_flg_due) begin
          r_flg[r_flg_idx]  <= flg_t'(i_flg);
          r_pend[r_flg_idx] <= 1'b0;
        end
        if (w_push) begin
          r_tag[r_tail]  <= i_res_tag;
          r_res[r_tail]  <= i_res;
          r_pend[r_tail] <= 1'b1;
          r_tail         <= r_tail + 1'b1;
          r_flg_idx      <= r_tail;
        end
        r_flg_due <= w_push;
        if (w_pop) r_head <= r_head + 1'b1;
      end
    end
  end
endmodule

// File: rtl/imul_wb_buf.sv
// Multiplier writeback buffer: tag delay line, capture FIFO and issue credit logic.
module imul_wb_buf
  import imul_wb_buf_pkg::*;
#(
  parameter int LAT   = IMUL_LAT,
  parameter int DEPTH = 4,
  parameter int TAG_W = IMUL_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             flush,
  input  logic             en,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [64:0]      Res,
  input  logic [5:0]       flg,
  output logic             out_vld,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [64:0]      out_res,
  output logic [5:0]       out_flg,
  output logic             issue_stall,
  output logic             ovf_err
);
  logic [LAT-1:0]        r_vld;
  logic [TAG_W-1:0]      r_tag [LAT];
  logic                  r_stall, r_ovf;

  logic [LAT-1:0]        w_vld_nxt;
  logic [7:0]            w_inflight, w_credit;
  logic [$clog2(DEPTH):0] w_cnt_nxt;
  logic                  w_cap;

  assign w_cap = clkEn && r_vld[LAT-1];

  always_comb begin
    w_vld_nxt = r_vld;
    if (flush)      w_vld_nxt = '0;
    else if (clkEn) w_vld_nxt = {r_vld[LAT-2:0], en};
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + 8'(w_vld_nxt[i]);
    w_credit = w_inflight + 8'(w_cnt_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (clkEn) begin
        r_tag[0] <= tag_in;
        for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Stall is computed from next-state occupancy so it already guards the following issue slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_stall <= (w_credit >= 8'(DEPTH));
      if (en && clkEn && r_stall) r_ovf <= 1'b1;
    end
  end

  assign issue_stall = r_stall;
  assign ovf_err     = r_ovf;

  imul_wb_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_res_we  (w_cap),
    .i_res_tag (r_tag[LAT-1]),
    .i_res     (Res),
    .i_flg     (flg),
    .i_pop     (out_ready),
    .o_vld     (out_vld),
    .o_tag     (out_tag),
    .o_res     (out_res),
    .o_flg     (out_flg),
    .o_cnt_nxt (w_cnt_nxt)
  );
endmodule
